// File: rtl/tick_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : tick_pkg                                                 |
// | Purpose   : Shared widths, tick record and writer FSM states for the |
// |             tick writer, price RAM and algorithm bank.               |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
package tick_pkg;

   localparam int STOCK_W    = 2;
   localparam int PRICE_W    = 14;
   localparam int SLOT_W     = 3;
   localparam int ADDR_W     = STOCK_W + SLOT_W;
   localparam int DATA_W     = STOCK_W + PRICE_W;
   localparam int NUM_STOCKS = 1 << STOCK_W;

   // Writer FSM: IDLE = nothing buffered, WRITE = draining, HOLD = frozen
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   // Packed layout matches the price-RAM word {stock, price}
   typedef struct packed {
      logic [STOCK_W-1:0] stock;
      logic [PRICE_W-1:0] price;
   } tick_t;

   // Limit a price to a ceiling when the clamp is enabled
   function automatic logic [PRICE_W-1:0] clamp_price(
      input logic [PRICE_W-1:0] price,
      input logic [PRICE_W-1:0] ceiling,
      input logic               en
   );
      return (en && (price > ceiling)) ? ceiling : price;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tick_writer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : tick_writer_if                                           |
// | Purpose   : Tick handshake input and price-RAM write port of the     |
// |             tick writer. slave = writer side, master = environment.  |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
interface tick_writer_if;
   import tick_pkg::*;

   logic               tick_valid;
   logic               tick_ready;
   logic [STOCK_W-1:0] tick_stock;
   logic [PRICE_W-1:0] tick_price;
   logic               we;
   logic [ADDR_W-1:0]  w_addr;
   logic [DATA_W-1:0]  data_out;

   modport master (
      output tick_valid, tick_stock, tick_price,
      input  tick_ready, we, w_addr, data_out
   );

   modport slave (
      input  tick_valid, tick_stock, tick_price,
      output tick_ready, we, w_addr, data_out
   );

endinterface
`default_nettype wire

// File: rtl/tick_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tick_fifo                                                |
// | Purpose   : Small synchronous FIFO buffering accepted ticks.         |
// |             DEPTH must be a power of two, at least 2. Pointers carry |
// |             one extra wrap bit to tell full from empty.              |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module tick_fifo
   import tick_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = DATA_W
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         din_i,
   output logic [WIDTH-1:0]         dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             push_w;
   logic             pop_w;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count_o = wr_ptr_q - rd_ptr_q;
   assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

   // Guard against overflow/underflow even if the caller misbehaves
   assign push_w = push_i & ~full_o;
   assign pop_w  = pop_i & ~empty_o;

   // Storage array; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (push_w) begin
         mem_q[wr_ptr_q[AW-1:0]] <= din_i;
      end
   end

   // Read/write pointers; reset empties the FIFO
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_w) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop_w)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/tick_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tick_writer                                              |
// | Purpose   : Buffers market ticks and writes them to the price RAM at |
// |             {stock, slot}, one write per cycle, with freeze, drop    |
// |             counting and an algorithm-bank enable.                   |
// | Options   : TICK_WRITER_CLAMP_EN - limit written prices to PRICE_MAX |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module tick_writer
   import tick_pkg::*;
#(
   parameter logic [PRICE_W-1:0] PRICE_MAX  = 14'd10000,
   parameter int                 FIFO_DEPTH = 4
)(
   input  logic             clk,
   input  logic             rst,
   tick_writer_if.slave     bus,
   input  logic             freeze,
   output logic             enable,
   output logic [7:0]       drop_cnt
);

`ifdef TICK_WRITER_CLAMP_EN
   localparam logic CLAMP_ON = 1'b1;
`else
   localparam logic CLAMP_ON = 1'b0;
`endif

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   tick_t              push_tick_w;
   tick_t              pop_tick_w;
   logic               fifo_full_w;
   logic               fifo_empty_w;
   logic [CNT_W-1:0]   fifo_count_w;
   logic               ready_w;
   logic               push_w;
   logic               pop_w;
   logic               occupied_next_w;

   state_e             state_q;
   state_e             state_d;
   logic               we_q;
   logic [ADDR_W-1:0]  w_addr_q;
   logic [DATA_W-1:0]  data_q;
   logic [SLOT_W-1:0]  slot_q [NUM_STOCKS];
   logic [NUM_STOCKS-1:0] seen_q;
   logic               enable_q;
   logic [7:0]         drop_q;

   // Ready is gated by reset so nothing is offered acceptance while held
   assign ready_w     = rst & ~fifo_full_w & ~freeze;
   assign push_w      = bus.tick_valid & ready_w;
   // HOLD needs one cycle after freeze drops before draining resumes
   assign pop_w       = (state_q != ST_HOLD) & ~freeze & ~fifo_empty_w;
   assign push_tick_w = {bus.tick_stock, bus.tick_price};

   // FIFO occupancy after this edge, without an adder
   assign occupied_next_w = push_w |
                            (~fifo_empty_w & ~(pop_w & (fifo_count_w == CNT_W'(1))));

   tick_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_w),
      .pop_i   (pop_w),
      .din_i   (push_tick_w),
      .dout_o  (pop_tick_w),
      .full_o  (fifo_full_w),
      .empty_o (fifo_empty_w),
      .count_o (fifo_count_w)
   );

   // Next FSM state: freeze dominates, otherwise follow FIFO occupancy
   always_comb begin
      state_d = state_q;
      if (freeze) begin
         state_d = ST_HOLD;
      end else if (occupied_next_w) begin
         state_d = ST_WRITE;
      end else begin
         state_d = ST_IDLE;
      end
   end

   // FSM state, registered RAM write port, slot pointers, seen bits, enable
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         we_q     <= 1'b0;
         w_addr_q <= '0;
         data_q   <= '0;
         seen_q   <= '0;
         enable_q <= 1'b0;
         for (int s = 0; s < NUM_STOCKS; s++) begin
            slot_q[s] <= '0;
         end
      end else begin
         state_q  <= state_d;
         we_q     <= pop_w;
         // seen bits lag by one edge, so enable rises the cycle after the write
         enable_q <= enable_q | (&seen_q);
         if (pop_w) begin
            w_addr_q <= {pop_tick_w.stock, slot_q[pop_tick_w.stock]};
            data_q   <= {pop_tick_w.stock,
                         clamp_price(pop_tick_w.price, PRICE_MAX, CLAMP_ON)};
            slot_q[pop_tick_w.stock] <= slot_q[pop_tick_w.stock] + SLOT_W'(1);
            seen_q[pop_tick_w.stock] <= 1'b1;
         end
      end
   end

   // Saturating count of cycles where a tick was offered but refused
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_q <= '0;
      end else if (bus.tick_valid && !ready_w && (drop_q != 8'hFF)) begin
         drop_q <= drop_q + 8'd1;
      end
   end

   assign bus.tick_ready = ready_w;
   assign bus.we         = we_q;
   assign bus.w_addr     = w_addr_q;
   assign bus.data_out   = data_q;
   assign enable         = enable_q;
   assign drop_cnt       = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_tick_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_tick_writer                                           |
// | Purpose   : Directed self-checking bench for tick_writer.            |
// |             Honours TICK_WRITER_CLAMP_EN for the clamp expectations. |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module tb_tick_writer;
   import tick_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       freeze;
   logic       enable;
   logic [7:0] drop_cnt;
   int         vec_cnt = 0;
   int         err_cnt = 0;

   tick_writer_if bus();

   tick_writer #(
      .PRICE_MAX  (14'd10000),
      .FIFO_DEPTH (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .freeze   (freeze),
      .enable   (enable),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] s, input logic [13:0] p);
      bus.tick_valid = v;
      bus.tick_stock = s;
      bus.tick_price = p;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      freeze = 1'b0;
      drive(1'b1, 2'd3, 14'd5);
      tick(); tick(); tick();
      vec_cnt++; if (bus.tick_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_ready: got %0b want 0", bus.tick_ready); end
      vec_cnt++; if (bus.we !== 1'b0) begin err_cnt++; $display("FAIL reset_we: got %0b want 0", bus.we); end
      vec_cnt++; if (bus.w_addr !== 5'd0 || bus.data_out !== 16'h0) begin err_cnt++; $display("FAIL reset_bus: addr %0d data %h want 0/0000", bus.w_addr, bus.data_out); end
      vec_cnt++; if (enable !== 1'b0 || drop_cnt !== 8'd0) begin err_cnt++; $display("FAIL reset_status: enable %0b drop %0d want 0/0", enable, drop_cnt); end
      drive(1'b0, 2'd0, 14'd0);
      rst = 1'b1;
      tick();
      vec_cnt++; if (bus.tick_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_release_ready: got %0b want 1", bus.tick_ready); end
   endtask

   task automatic test_single();
      drive(1'b1, 2'd2, 14'd500);
      tick();
      vec_cnt++; if (bus.we !== 1'b0) begin err_cnt++; $display("FAIL single_we_early: got %0b want 0", bus.we); end
      drive(1'b0, 2'd0, 14'd0);
      tick();
      vec_cnt++; if (bus.we !== 1'b1) begin err_cnt++; $display("FAIL single_we: got %0b want 1", bus.we); end
      vec_cnt++; if (bus.w_addr !== 5'b10000) begin err_cnt++; $display("FAIL single_addr: got %b want 10000", bus.w_addr); end
      vec_cnt++; if (bus.data_out !== 16'h81F4) begin err_cnt++; $display("FAIL single_data: got %h want 81f4", bus.data_out); end
      tick();
      vec_cnt++; if (bus.we !== 1'b0) begin err_cnt++; $display("FAIL single_we_strobe: got %0b want 0", bus.we); end
   endtask

   task automatic test_wrap();
      logic [4:0]  exp_a;
      logic [15:0] exp_d;
      drive(1'b1, 2'd1, 14'd100);
      for (int k = 0; k < 10; k++) begin
         tick();
         if (k >= 1) begin
            exp_a = 5'(8 + ((k - 1) % 8));
            exp_d = {2'b01, 14'(100 + k - 1)};
            vec_cnt++;
            if (bus.we !== 1'b1 || bus.w_addr !== exp_a || bus.data_out !== exp_d) begin
               err_cnt++;
               $display("FAIL wrap_%0d: we %0b addr %0d data %h want 1/%0d/%h", k - 1, bus.we, bus.w_addr, bus.data_out, exp_a, exp_d);
            end
         end
         if (k < 8) bus.tick_price = 14'(100 + k + 1);
         else       bus.tick_valid = 1'b0;
      end
      tick();
      vec_cnt++; if (bus.we !== 1'b0) begin err_cnt++; $display("FAIL wrap_end_we: got %0b want 0", bus.we); end
   endtask

   task automatic test_backpressure();
      int k;
      freeze = 1'b1;
      drive(1'b1, 2'd0, 14'd7);
      for (int c = 0; c < 6; c++) begin
         tick();
         vec_cnt++;
         if (bus.tick_ready !== 1'b0 || bus.we !== 1'b0) begin
            err_cnt++;
            $display("FAIL bp_cycle_%0d: ready %0b we %0b want 0/0", c, bus.tick_ready, bus.we);
         end
      end
      vec_cnt++; if (drop_cnt !== 8'd6) begin err_cnt++; $display("FAIL bp_drop6: got %0d want 6", drop_cnt); end
      for (int c = 0; c < 253; c++) tick();
      vec_cnt++; if (drop_cnt !== 8'd255) begin err_cnt++; $display("FAIL bp_drop_sat: got %0d want 255", drop_cnt); end
      freeze = 1'b0;
      #1;
      vec_cnt++; if (bus.tick_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_release_ready: got %0b want 1", bus.tick_ready); end
      tick();
      drive(1'b0, 2'd0, 14'd0);
      k = 0;
      while (k < 5 && bus.we !== 1'b1) begin tick(); k++; end
      vec_cnt++;
      if (bus.we !== 1'b1) begin
         err_cnt++; $display("FAIL bp_write_timeout: we %0b after %0d cycles want 1", bus.we, k);
      end else if (bus.w_addr !== 5'd0 || bus.data_out !== 16'h0007) begin
         err_cnt++; $display("FAIL bp_write: addr %0d data %h want 0/0007", bus.w_addr, bus.data_out);
      end
      vec_cnt++; if (drop_cnt !== 8'd255) begin err_cnt++; $display("FAIL bp_drop_hold: got %0d want 255", drop_cnt); end
      tick();
   endtask

   task automatic test_enable();
      vec_cnt++; if (enable !== 1'b0) begin err_cnt++; $display("FAIL enable_three: got %0b want 0", enable); end
      drive(1'b1, 2'd3, 14'd3);
      tick();
      drive(1'b0, 2'd0, 14'd0);
      tick();
      vec_cnt++;
      if (bus.we !== 1'b1 || bus.w_addr !== 5'd24 || bus.data_out !== 16'hC003) begin
         err_cnt++; $display("FAIL enable_write: we %0b addr %0d data %h want 1/24/c003", bus.we, bus.w_addr, bus.data_out);
      end
      vec_cnt++; if (enable !== 1'b0) begin err_cnt++; $display("FAIL enable_early: got %0b want 0", enable); end
      tick();
      vec_cnt++; if (enable !== 1'b1) begin err_cnt++; $display("FAIL enable_set: got %0b want 1", enable); end
   endtask

   task automatic test_clamp();
      logic [13:0] prices [3];
      logic [13:0] expect_p [3];
      prices[0] = 14'd12000; prices[1] = 14'd10000; prices[2] = 14'd16383;
`ifdef TICK_WRITER_CLAMP_EN
      expect_p[0] = 14'd10000; expect_p[1] = 14'd10000; expect_p[2] = 14'd10000;
`else
      expect_p[0] = 14'd12000; expect_p[1] = 14'd10000; expect_p[2] = 14'd16383;
`endif
      drive(1'b1, 2'd0, prices[0]);
      for (int k = 0; k < 4; k++) begin
         tick();
         if (k >= 1) begin
            vec_cnt++;
            if (bus.we !== 1'b1 || bus.w_addr !== 5'(k) || bus.data_out !== {2'b00, expect_p[k-1]}) begin
               err_cnt++;
               $display("FAIL clamp_%0d: we %0b addr %0d price %0d want 1/%0d/%0d", k - 1, bus.we, bus.w_addr, bus.data_out[13:0], k, expect_p[k-1]);
            end
         end
         if (k < 2) bus.tick_price = prices[k+1];
         else       bus.tick_valid = 1'b0;
      end
      tick();
   endtask

   task automatic test_freeze_hold();
      int nwr;
      freeze = 1'b1;
      drive(1'b0, 2'd0, 14'd0);
      tick();
      for (int i = 0; i < 3; i++) begin
         freeze = 1'b0;
         drive(1'b1, 2'd2, 14'(300 + i));
         tick();
         freeze = 1'b1;
         drive(1'b0, 2'd0, 14'd0);
         tick();
         vec_cnt++; if (bus.we !== 1'b0) begin err_cnt++; $display("FAIL hold_accum_%0d_we: got %0b want 0", i, bus.we); end
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         vec_cnt++;
         if (bus.we !== 1'b0 || bus.tick_ready !== 1'b0) begin
            err_cnt++; $display("FAIL hold_frozen_%0d: we %0b ready %0b want 0/0", c, bus.we, bus.tick_ready);
         end
      end
      freeze = 1'b0;
      nwr = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (bus.we === 1'b1) begin
            vec_cnt++;
            if (nwr >= 3) begin
               err_cnt++; $display("FAIL hold_extra_write: addr %0d data %h want no write", bus.w_addr, bus.data_out);
            end else if (bus.w_addr !== 5'(17 + nwr) || bus.data_out !== {2'b10, 14'(300 + nwr)}) begin
               err_cnt++; $display("FAIL hold_drain_%0d: addr %0d data %h want %0d/%h", nwr, bus.w_addr, bus.data_out, 17 + nwr, {2'b10, 14'(300 + nwr)});
            end
            nwr++;
         end
      end
      vec_cnt++; if (nwr != 3) begin err_cnt++; $display("FAIL hold_drain_count: got %0d want 3", nwr); end
   endtask

   task automatic test_reset_midburst();
      int nwr;
      freeze = 1'b1;
      drive(1'b0, 2'd0, 14'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         freeze = 1'b0;
         drive(1'b1, 2'd1, 14'(200 + i));
         tick();
         freeze = 1'b1;
         drive(1'b0, 2'd0, 14'd0);
         tick();
      end
      freeze = 1'b0;
      #1;
      vec_cnt++; if (bus.tick_ready !== 1'b0) begin err_cnt++; $display("FAIL full_ready: got %0b want 0", bus.tick_ready); end
      rst = 1'b0;
      #1;
      vec_cnt++; if (bus.tick_ready !== 1'b0 || bus.we !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_hs: ready %0b we %0b want 0/0", bus.tick_ready, bus.we); end
      vec_cnt++; if (bus.w_addr !== 5'd0 || bus.data_out !== 16'h0) begin err_cnt++; $display("FAIL mid_rst_bus: addr %0d data %h want 0/0000", bus.w_addr, bus.data_out); end
      vec_cnt++; if (enable !== 1'b0 || drop_cnt !== 8'd0) begin err_cnt++; $display("FAIL mid_rst_status: enable %0b drop %0d want 0/0", enable, drop_cnt); end
      tick(); tick();
      rst = 1'b1;
      drive(1'b1, 2'd0, 14'd42);
      tick();
      drive(1'b0, 2'd0, 14'd0);
      nwr = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (bus.we === 1'b1) begin
            vec_cnt++;
            if (nwr > 0) begin
               err_cnt++; $display("FAIL mid_rst_stale_write: addr %0d data %h want no write", bus.w_addr, bus.data_out);
            end else if (bus.w_addr !== 5'd0 || bus.data_out !== 16'h002A) begin
               err_cnt++; $display("FAIL mid_rst_write: addr %0d data %h want 0/002a", bus.w_addr, bus.data_out);
            end
            nwr++;
         end
      end
      vec_cnt++; if (nwr != 1) begin err_cnt++; $display("FAIL mid_rst_write_count: got %0d want 1", nwr); end
   endtask

   initial begin
      rst    = 1'b0;
      freeze = 1'b0;
      drive(1'b0, 2'd0, 14'd0);
      test_reset();
      test_single();
      test_wrap();
      test_backpressure();
      test_enable();
      test_clamp();
      test_freeze_hold();
      test_reset_midburst();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, vectors %0d", vec_cnt);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/tick_writer.md
TICK_WRITER -- requirements
Module: tick_writer

Interface
REQ-001 Parameter PRICE_MAX, default 14'd10000; ceiling applied to prices when clamping is compiled in.
REQ-002 Parameter FIFO_DEPTH, default 4; tick buffer entries, power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 tick_valid  input  1  upstream tick offered.
REQ-006 tick_ready  output  1  tick accepted when tick_valid and tick_ready are both high on a rising edge.
REQ-007 tick_stock  input  2  stock id of the offered tick.
REQ-008 tick_price  input  14  price of the offered tick, unsigned.
REQ-009 freeze  input  1  stop accepting and writing ticks; buffered ticks are held.
REQ-010 we  output  1  price-RAM write strobe.
REQ-011 w_addr  output  5  price-RAM write address.
REQ-012 data_out  output  16  price-RAM write word {stock[1:0], price[13:0]}.
REQ-013 enable  output  1  algorithm-bank enable; high once every stock has at least one stored sample.
REQ-014 drop_cnt  output  8  count of cycles with tick_valid high and tick_ready low, saturating at 255.

Function
REQ-015 tick_ready SHALL equal (FIFO not full) AND (freeze low), driven combinationally from registered state only.
REQ-016 Accepted ticks SHALL be stored in a FIFO_DEPTH-entry FIFO, in order, with no loss or duplication.
REQ-017 The FSM SHALL have states IDLE (FIFO empty), WRITE (popping one entry per cycle) and HOLD (freeze high).
- IDLE->WRITE when FIFO is non-empty and freeze is low.
- WRITE->IDLE when the last entry is popped.
- Any state->HOLD when freeze is high; HOLD->IDLE/WRITE when freeze goes low, based on FIFO occupancy.
REQ-018 A tick accepted at edge N into an empty FIFO with freeze low SHALL produce we=1 in cycle N+1; there SHALL be at most one write per cycle.
REQ-019 we, w_addr and data_out SHALL be registered outputs; we SHALL be a single-cycle strobe per popped entry.
REQ-020 w_addr SHALL be {stock, slot}, where slot is a 3-bit per-stock write pointer that increments after each write and wraps from 7 to 0.
REQ-021 A simultaneous push and pop SHALL keep occupancy unchanged; a push while full cannot occur because tick_ready is low.
REQ-022 A per-stock "seen" bit SHALL set on that stock's first write; enable SHALL go high the cycle after the write that sets the fourth bit, and stay high until reset.
REQ-023 freeze asserted mid-burst SHALL suppress we from the next cycle; FIFO contents and slot pointers SHALL be retained.
REQ-024 drop_cnt SHALL increment by 1 per stalled-valid cycle and hold at 255.

Reset
REQ-025 While rst is low: tick_ready=0, we=0, w_addr=0, data_out=0, enable=0, drop_cnt=0, FIFO empty, all slot pointers 0, seen bits 0, FSM=IDLE.
REQ-026 Reset asserted mid-burst SHALL discard all buffered ticks; the first write after release SHALL go to slot 0.

Configuration
REQ-027 With macro TICK_WRITER_CLAMP_EN defined, a price greater than PRICE_MAX SHALL be written as PRICE_MAX; without the macro, the price SHALL be written unmodified. Ports and latency SHALL be identical in both builds.

Structure
REQ-028 Package tick_pkg SHALL hold STOCK_W=2, PRICE_W=14, SLOT_W=3, ADDR_W=5, DATA_W=16 and the FSM state enum; the price-RAM and algorithm blocks SHALL share these widths.
REQ-029 The FIFO SHALL be a sub-module named tick_fifo (push/pop/full/empty/count); the FSM, address generation, clamp logic and counters SHALL live in tick_writer.

Verification
REQ-030 Single tick: stock=2, price=500 accepted at edge N -> we=1 in cycle N+1, w_addr=5'b10000, data_out=16'h81F4; all other cycles have we=0.
REQ-031 Wrap: 9 ticks on stock 1 -> w_addr sequence 8,9,...,15,8; the 9th tick overwrites slot 0.
REQ-032 Back-pressure: freeze=1 with tick_valid held high for 6 cycles -> tick_ready=0, drop_cnt=6, no we; after freeze=0 -> the ticks are accepted.
REQ-033 Enable: ticks on stocks 0,1,2 -> enable=0; then a tick on stock 3 -> enable=1 the cycle after its write.
REQ-034 Clamp (macro defined): price 14'd12000 -> data_out[13:0]=10000; with the macro undefined -> 12000.
REQ-035 Reset mid-burst: 4 ticks buffered, rst pulsed low -> all outputs 0 immediately; a subsequent stock-0 tick is written to w_addr=0.
